id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage of the 64-bit RISC-V core. It captures a decoded instruction together with the two operands read from the register file in the same cycle. It resolves RAW hazards by forwarding from the EX, MEM and WB stages, and it stalls for one bubble on a load-use dependency. It presents a registered, valid/ready-handshaked operand bundle to the ALU/EX stage.

---
 rtl/id_ex_stage.sv | 184 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX register: captures decoded instruction, forwards operands from EX/MEM/WB, inserts one bubble on load-use.
// Latency 1 cycle; holds payload while out_valid && !out_ready, in_ready drops on backpressure or hazard.
module id_ex_stage #(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [REGW-1:0] rs1,
  input  logic [REGW-1:0] rs2,
  input  logic [REGW-1:0] rd,
  input  logic            usesRs1,
  input  logic            usesRs2,
  input  logic [3:0]      aluOp,
  input  logic            aluSrc,
  input  logic            memRead,
  input  logic            memWrite,
  input  logic            regWrite,
  input  logic            memToReg,
  input  logic            branch,
  input  logic [XLEN-1:0] readData1,
  input  logic [XLEN-1:0] readData2,
  input  logic            ex_valid,
  input  logic            ex_regWrite,
  input  logic            ex_memRead,
  input  logic [REGW-1:0] ex_rd,
  input  logic [XLEN-1:0] ex_result,
  input  logic            mem_valid,
  input  logic            mem_regWrite,
  input  logic [REGW-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_regWrite,
  input  logic [REGW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_opA,
  output logic [XLEN-1:0] out_opB,
  output logic [REGW-1:0] out_rs1,
  output logic [REGW-1:0] out_rs2,
  output logic [REGW-1:0] out_rd,
  output logic [3:0]      out_aluOp,
  output logic            out_aluSrc,
  output logic            out_memRead,
  output logic            out_memWrite,
  output logic            out_regWrite,
  output logic            out_memToReg,
  output logic            out_branch,
  output logic [31:0]     stallCount
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q, imm_q, opa_q, opb_q;
  logic [REGW-1:0] rs1_q, rs2_q, rd_q;
  logic [3:0]      alu_op_q;
  logic            alu_src_q, mem_read_q, mem_write_q, reg_write_q, mem_to_reg_q, branch_q;
  logic [31:0]     stall_cnt_q;

  logic            adv;
  logic            hazard;
  logic            capture;
  logic [XLEN-1:0] opa_d, opb_d;

  // A load in EX has no data yet, so its result is excluded here and covered by the stall.
  function automatic logic [XLEN-1:0] fwd(
    input logic [REGW-1:0] idx,
    input logic [XLEN-1:0] rf_data,
    input logic            exv, exrw, exmr,
    input logic [REGW-1:0] exrd,
    input logic [XLEN-1:0] exres,
    input logic            memv, memrw,
    input logic [REGW-1:0] memrd,
    input logic [XLEN-1:0] memres,
    input logic            wbrw,
    input logic [REGW-1:0] wbrd,
    input logic [XLEN-1:0] wbdat
  );
    logic [XLEN-1:0] r;
    r = rf_data;
    if (idx == '0)
      r = '0;
    else if (exv && exrw && !exmr && exrd == idx)
      r = exres;
    else if (memv && memrw && memrd == idx)
      r = memres;
    else if (wbrw && wbrd == idx)
      r = wbdat;
    return r;
  endfunction

  always_comb begin
    opa_d = fwd(rs1, readData1, ex_valid, ex_regWrite, ex_memRead, ex_rd, ex_result,
                mem_valid, mem_regWrite, mem_rd, mem_result, wb_regWrite, wb_rd, wb_data);
    opb_d = fwd(rs2, readData2, ex_valid, ex_regWrite, ex_memRead, ex_rd, ex_result,
                mem_valid, mem_regWrite, mem_rd, mem_result, wb_regWrite, wb_rd, wb_data);
  end

  always_comb begin
    hazard = in_valid && ex_valid && ex_memRead && ex_regWrite && (ex_rd != '0) &&
             ((usesRs1 && rs1 == ex_rd) || (usesRs2 && rs2 == ex_rd));
    adv      = !valid_q || out_ready;
    in_ready = flush ? adv : (adv && !hazard);
    capture  = in_valid && in_ready && !flush;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
    end else if (adv) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q         <= '0;
      imm_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      alu_op_q     <= '0;
      alu_src_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      branch_q     <= 1'b0;
    end else if (capture) begin
      pc_q         <= pc;
      imm_q        <= imm;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      rs1_q        <= rs1;
      rs2_q        <= rs2;
      rd_q         <= rd;
      alu_op_q     <= aluOp;
      alu_src_q    <= aluSrc;
      mem_read_q   <= memRead;
      mem_write_q  <= memWrite;
      reg_write_q  <= regWrite;
      mem_to_reg_q <= memToReg;
      branch_q     <= branch;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (hazard && !flush && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_imm      = imm_q;
  assign out_opA      = opa_q;
  assign out_opB      = opb_q;
  assign out_rs1      = rs1_q;
  assign out_rs2      = rs2_q;
  assign out_rd       = rd_q;
  assign out_aluOp    = alu_op_q;
  assign out_aluSrc   = alu_src_q;
  assign out_memRead  = mem_read_q;
  assign out_memWrite = mem_write_q;
  assign out_regWrite = reg_write_q;
  assign out_memToReg = mem_to_reg_q;
  assign out_branch   = branch_q;
  assign stallCount   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: forwarding priority, load-use bubble, backpressure, flush, async reset.
module tb_id_ex_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [63:0] pc, imm;
  logic [4:0]  rs1, rs2, rd;
  logic        usesRs1, usesRs2;
  logic [3:0]  aluOp;
  logic        aluSrc, memRead, memWrite, regWrite, memToReg, branch;
  logic [63:0] readData1, readData2;
  logic        ex_valid, ex_regWrite, ex_memRead;
  logic [4:0]  ex_rd;
  logic [63:0] ex_result;
  logic        mem_valid, mem_regWrite;
  logic [4:0]  mem_rd;
  logic [63:0] mem_result;
  logic        wb_regWrite;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [63:0] out_pc, out_imm, out_opA, out_opB;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_aluOp;
  logic        out_aluSrc, out_memRead, out_memWrite, out_regWrite, out_memToReg, out_branch;
  logic [31:0] stallCount;

  always #5 clock = ~clock;

  id_ex_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .usesRs1(usesRs1), .usesRs2(usesRs2),
    .aluOp(aluOp), .aluSrc(aluSrc), .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
    .memToReg(memToReg), .branch(branch), .readData1(readData1), .readData2(readData2),
    .ex_valid(ex_valid), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_rd(ex_rd),
    .ex_result(ex_result), .mem_valid(mem_valid), .mem_regWrite(mem_regWrite), .mem_rd(mem_rd),
    .mem_result(mem_result), .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
    .out_opA(out_opA), .out_opB(out_opB), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_aluOp(out_aluOp), .out_aluSrc(out_aluSrc), .out_memRead(out_memRead),
    .out_memWrite(out_memWrite), .out_regWrite(out_regWrite), .out_memToReg(out_memToReg),
    .out_branch(out_branch), .stallCount(stallCount)
  );

  typedef struct {
    logic        in_valid, flush, out_ready, u1, u2;
    logic [4:0]  rs1, rs2;
    logic [63:0] rd1, rd2;
    logic        ex_valid, ex_rw, ex_mr;
    logic [4:0]  ex_rd;
    logic [63:0] ex_res;
    logic        mem_valid, mem_rw;
    logic [4:0]  mem_rd;
    logic [63:0] mem_res;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [63:0] wb_dat;
    logic        exp_rdy, exp_vld;
    logic [63:0] exp_a, exp_b;
    logic [31:0] exp_stall;
  } vec_t;

  vec_t tbl[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t dflt();
    vec_t v;
    v.in_valid = 1; v.flush = 0; v.out_ready = 1; v.u1 = 1; v.u2 = 1;
    v.rs1 = 5'd1; v.rs2 = 5'd2; v.rd1 = 64'h5; v.rd2 = 64'h7;
    v.ex_valid = 0; v.ex_rw = 0; v.ex_mr = 0; v.ex_rd = 0; v.ex_res = 0;
    v.mem_valid = 0; v.mem_rw = 0; v.mem_rd = 0; v.mem_res = 0;
    v.wb_rw = 0; v.wb_rd = 0; v.wb_dat = 0;
    v.exp_rdy = 1; v.exp_vld = 1; v.exp_a = 64'h5; v.exp_b = 64'h7; v.exp_stall = 0;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic [63:0] p, input logic [4:0] d);
    in_valid = v.in_valid; flush = v.flush; out_ready = v.out_ready;
    usesRs1 = v.u1; usesRs2 = v.u2; rs1 = v.rs1; rs2 = v.rs2;
    readData1 = v.rd1; readData2 = v.rd2;
    ex_valid = v.ex_valid; ex_regWrite = v.ex_rw; ex_memRead = v.ex_mr; ex_rd = v.ex_rd; ex_result = v.ex_res;
    mem_valid = v.mem_valid; mem_regWrite = v.mem_rw; mem_rd = v.mem_rd; mem_result = v.mem_res;
    wb_regWrite = v.wb_rw; wb_rd = v.wb_rd; wb_data = v.wb_dat;
    pc = p; imm = ~p; rd = d; aluOp = d[3:0]; aluSrc = d[0];
    memRead = 0; memWrite = d[1]; regWrite = 1; memToReg = 0; branch = d[2];
  endtask

  initial begin
    vec_t v;
    v = dflt();
    reset = 1'b0;
    drive(v, 64'h0, 5'd0);
    in_valid = 0;
    #3;
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset stallCount", {32'd0, stallCount}, 64'd0);
    check("reset out_pc", out_pc, 64'd0);
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clock);
    reset = 1'b1;

    // v0-v2: plain back-to-back
    for (int i = 0; i < 3; i++) tbl.push_back(dflt());
    // v3: EX beats MEM
    v = dflt(); v.rs1 = 3; v.ex_valid = 1; v.ex_rw = 1; v.ex_rd = 3; v.ex_res = 64'hAA;
    v.mem_valid = 1; v.mem_rw = 1; v.mem_rd = 3; v.mem_res = 64'hBB; v.exp_a = 64'hAA; tbl.push_back(v);
    // v4: MEM beats WB
    v = dflt(); v.rs1 = 6; v.mem_valid = 1; v.mem_rw = 1; v.mem_rd = 6; v.mem_res = 64'hBB;
    v.wb_rw = 1; v.wb_rd = 6; v.wb_dat = 64'hCC; v.exp_a = 64'hBB; tbl.push_back(v);
    // v5: WB path
    v = dflt(); v.rs2 = 4; v.rd2 = 64'h4; v.wb_rw = 1; v.wb_rd = 4; v.wb_dat = 64'h1234;
    v.exp_b = 64'h1234; tbl.push_back(v);
    // v6: x0 never forwarded
    v = dflt(); v.rs1 = 0; v.rs2 = 0; v.rd2 = 64'h4; v.wb_rw = 1; v.wb_rd = 0; v.wb_dat = 64'h1234;
    v.exp_a = 0; v.exp_b = 0; tbl.push_back(v);
    // v7: load in EX, rs1 matches but unused: no stall, no EX forward
    v = dflt(); v.u1 = 0; v.rs1 = 5; v.rd1 = 64'h55; v.ex_valid = 1; v.ex_rw = 1; v.ex_mr = 1;
    v.ex_rd = 5; v.ex_res = 64'hEE; v.exp_a = 64'h55; tbl.push_back(v);
    // v8: load-use stall
    v = dflt(); v.rs1 = 5; v.ex_valid = 1; v.ex_rw = 1; v.ex_mr = 1; v.ex_rd = 5; v.ex_res = 64'hEE;
    v.exp_rdy = 0; v.exp_vld = 0; v.exp_stall = 1; tbl.push_back(v);
    // v9: load now in MEM
    v = dflt(); v.rs1 = 5; v.mem_valid = 1; v.mem_rw = 1; v.mem_rd = 5; v.mem_res = 64'h99;
    v.exp_a = 64'h99; v.exp_stall = 1; tbl.push_back(v);
    // v10: hazard with flush: no count, nothing captured
    v = dflt(); v.rs1 = 5; v.flush = 1; v.ex_valid = 1; v.ex_rw = 1; v.ex_mr = 1; v.ex_rd = 5;
    v.exp_rdy = 1; v.exp_vld = 0; v.exp_stall = 1; tbl.push_back(v);
    // v11: load to x0 is not a hazard
    v = dflt(); v.rs1 = 0; v.ex_valid = 1; v.ex_rw = 1; v.ex_mr = 1; v.ex_rd = 0;
    v.exp_a = 0; v.exp_stall = 1; tbl.push_back(v);
    // v12: WB index match without write enable
    v = dflt(); v.wb_rw = 0; v.wb_rd = 2; v.wb_dat = 64'hFF; v.exp_stall = 1; tbl.push_back(v);

    foreach (tbl[i]) begin
      logic [63:0] p;
      logic [4:0]  d;
      p = 64'h1000 + 64'(i) * 4;
      d = 5'(i + 1);
      drive(tbl[i], p, d);
      #1;
      check($sformatf("v%0d in_ready", i), {63'd0, in_ready}, {63'd0, tbl[i].exp_rdy});
      @(posedge clock); #1;
      check($sformatf("v%0d out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].exp_vld});
      check($sformatf("v%0d stallCount", i), {32'd0, stallCount}, {32'd0, tbl[i].exp_stall});
      if (tbl[i].exp_vld) begin
        check($sformatf("v%0d out_opA", i), out_opA, tbl[i].exp_a);
        check($sformatf("v%0d out_opB", i), out_opB, tbl[i].exp_b);
        check($sformatf("v%0d out_pc", i), out_pc, p);
        check($sformatf("v%0d out_imm", i), out_imm, ~p);
        check($sformatf("v%0d out_rd", i), {59'd0, out_rd}, {59'd0, d});
      end
      @(negedge clock);
    end

    // backpressure: capture, then hold for 4 cycles with new inputs present
    v = dflt(); v.rd1 = 64'h11;
    drive(v, 64'h500, 5'd9);
    @(posedge clock); #1;
    check("bp capture valid", {63'd0, out_valid}, 64'd1);
    @(negedge clock);
    for (int c = 0; c < 4; c++) begin
      v = dflt(); v.out_ready = 0; v.rd1 = 64'h22 + 64'(c);
      drive(v, 64'h600 + 64'(c), 5'd10);
      #1;
      check($sformatf("bp%0d in_ready", c), {63'd0, in_ready}, 64'd0);
      @(posedge clock); #1;
      check($sformatf("bp%0d out_valid", c), {63'd0, out_valid}, 64'd1);
      check($sformatf("bp%0d out_pc", c), out_pc, 64'h500);
      check($sformatf("bp%0d out_opA", c), out_opA, 64'h11);
      check($sformatf("bp%0d out_rd", c), {59'd0, out_rd}, 64'd9);
      @(negedge clock);
    end
    v = dflt(); v.out_ready = 0; v.flush = 1;
    drive(v, 64'h700, 5'd11);
    @(posedge clock); #1;
    check("flush out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clock);

    // build up a stall and a valid bundle, then reset asynchronously
    v = dflt(); v.rs1 = 5; v.ex_valid = 1; v.ex_rw = 1; v.ex_mr = 1; v.ex_rd = 5;
    drive(v, 64'h800, 5'd12);
    @(posedge clock); #1;
    check("pre-reset stallCount", {32'd0, stallCount}, 64'd2);
    @(negedge clock);
    v = dflt();
    drive(v, 64'h804, 5'd13);
    @(posedge clock); #1;
    check("pre-reset out_valid", {63'd0, out_valid}, 64'd1);
    v = dflt(); v.rs1 = 5; v.ex_valid = 1; v.ex_rw = 1; v.ex_mr = 1; v.ex_rd = 5;
    drive(v, 64'h808, 5'd14);
    #1;
    reset = 1'b0;
    #1;
    check("async reset out_valid", {63'd0, out_valid}, 64'd0);
    check("async reset stallCount", {32'd0, stallCount}, 64'd0);
    check("async reset out_pc", out_pc, 64'd0);
    check("in_ready in reset w/ hazard", {63'd0, in_ready}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    v = dflt(); v.rd1 = 64'h77;
    drive(v, 64'h900, 5'd15);
    #1;
    check("post-reset in_ready", {63'd0, in_ready}, 64'd1);
    check("post-reset pre-edge valid", {63'd0, out_valid}, 64'd0);
    @(posedge clock); #1;
    check("post-reset out_valid", {63'd0, out_valid}, 64'd1);
    check("post-reset out_pc", out_pc, 64'h900);
    check("post-reset out_opA", out_opA, 64'h77);
    check("post-reset stallCount", {32'd0, stallCount}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
